// File: rtl/closest_hit_ctrl.sv
// closest_hit_ctrl: walks a triangle list through the combinational ray/triangle
// intersection datapath, one triangle at a time, and keeps the nearest valid hit.
module closest_hit_ctrl #(
    parameter int IDX_W     = 16,
    parameter int ISECT_LAT = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [0:1][0:2][31:0] i_ray,
    input  logic [IDX_W-1:0]      i_num_tri,
    output logic                  o_busy,
    output logic                  o_tri_rd,
    output logic [IDX_W-1:0]      o_tri_addr,
    input  logic                  i_tri_valid,
    input  logic [0:2][0:2][31:0] i_tri_data,
    output logic [0:2][0:2][31:0] o_isect_triangle,
    output logic [0:1][0:2][31:0] o_isect_ray,
    input  logic                  i_isect_result,
    input  logic                  i_isect_invalid,
    input  logic [31:0]           i_isect_t,
    input  logic [0:2][31:0]      i_isect_normal,
    output logic                  o_done,
    output logic                  o_hit,
    output logic [IDX_W-1:0]      o_hit_idx,
    output logic [31:0]           o_hit_t,
    output logic [0:2][31:0]      o_hit_normal,
    output logic [IDX_W-1:0]      o_invalid_cnt
);

    localparam int CNT_W = (ISECT_LAT < 2) ? 1 : $clog2(ISECT_LAT + 1);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(ISECT_LAT);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] FETCH    = 3'd1;
    localparam logic [2:0] WAIT_MEM = 3'd2;
    localparam logic [2:0] EVAL     = 3'd3;
    localparam logic [2:0] DONE     = 3'd4;
    localparam logic [2:0] DRAIN    = 3'd5;

    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [IDX_W-1:0] num_tri;
    logic [CNT_W-1:0] eval_cnt;
    logic             accept;
    logic             capture;
    logic             sample;
    logic             last_eval;
    logic             last_tri;
    logic             closer;

    // o_tri_addr doubles as the running triangle index.
    assign accept    = (state == IDLE) && i_start && !i_abort;
    assign capture   = (state == WAIT_MEM) && i_tri_valid && !i_abort;
    assign last_eval = (eval_cnt == CNT_W'(1));
    assign sample    = (state == EVAL) && last_eval && !i_abort;
    assign last_tri  = (o_tri_addr == num_tri - IDX_W'(1));
    assign closer    = !o_hit || ($signed(i_isect_t) < $signed(o_hit_t));

    assign o_busy   = (state != IDLE);
    assign o_tri_rd = (state == FETCH) && !i_abort;
    assign o_done   = (state == DONE) && !i_abort;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (i_start) state_nxt = (i_num_tri == '0) ? DONE : FETCH;
            FETCH:    state_nxt = WAIT_MEM;
            WAIT_MEM: if (i_tri_valid) state_nxt = EVAL;
            EVAL:     if (last_eval) state_nxt = last_tri ? DONE : FETCH;
            DONE:     state_nxt = IDLE;
            DRAIN:    if (i_tri_valid) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
        // An abort in WAIT_MEM must still swallow the one outstanding response.
        if (i_abort) begin
            if (state == WAIT_MEM) begin
                state_nxt = i_tri_valid ? IDLE : DRAIN;
            end else if (state != DRAIN) begin
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            num_tri  <= '0;
            eval_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                num_tri <= i_num_tri;
            end
            if (capture) begin
                eval_cnt <= LAT_LOAD;
            end else if ((state == EVAL) && !last_eval) begin
                eval_cnt <= eval_cnt - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_isect_ray      <= '0;
            o_isect_triangle <= '0;
        end else begin
            if (accept) begin
                o_isect_ray <= i_ray;
            end
            if (capture) begin
                o_isect_triangle <= i_tri_data;
            end
        end
    end

    // Strict less-than keeps the earlier index on equal distances.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_tri_addr    <= '0;
            o_hit         <= 1'b0;
            o_hit_idx     <= '0;
            o_hit_t       <= '0;
            o_hit_normal  <= '0;
            o_invalid_cnt <= '0;
        end else if (accept) begin
            o_tri_addr    <= '0;
            o_hit         <= 1'b0;
            o_hit_idx     <= '0;
            o_hit_t       <= '0;
            o_hit_normal  <= '0;
            o_invalid_cnt <= '0;
        end else if (sample) begin
            if (i_isect_invalid) begin
                if (o_invalid_cnt != '1) begin
                    o_invalid_cnt <= o_invalid_cnt + IDX_W'(1);
                end
            end else if (i_isect_result && closer) begin
                o_hit        <= 1'b1;
                o_hit_idx    <= o_tri_addr;
                o_hit_t      <= i_isect_t;
                o_hit_normal <= i_isect_normal;
            end
            if (!last_tri) begin
                o_tri_addr <= o_tri_addr + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_closest_hit_ctrl.sv
// tb_closest_hit_ctrl: directed traversals of closest_hit_ctrl (ISECT_LAT 1 and 3)
// checked every cycle against a list-level model of the expected timeline and result.
`timescale 1ns/1ps
module tb_closest_hit_ctrl;

    localparam int IDX_W = 16;
    localparam int MAXT  = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic                  abort;
    logic                  sel;
    logic [0:1][0:2][31:0] ray;
    logic [IDX_W-1:0]      num_tri;
    logic                  tri_valid;
    logic [0:2][0:2][31:0] tri_data;
    logic                  isect_result;
    logic                  isect_invalid;
    logic [31:0]           isect_t;
    logic [0:2][31:0]      isect_normal;

    logic                  busy_v [2];
    logic                  rd_v   [2];
    logic [IDX_W-1:0]      addr_v [2];
    logic [0:2][0:2][31:0] itri_v [2];
    logic [0:1][0:2][31:0] iray_v [2];
    logic                  done_v [2];
    logic                  hit_v  [2];
    logic [IDX_W-1:0]      hidx_v [2];
    logic [31:0]           ht_v   [2];
    logic [0:2][31:0]      hn_v   [2];
    logic [IDX_W-1:0]      inv_v  [2];

    always #5 clk = ~clk;

    // Instance 0 uses ISECT_LAT=1, instance 1 uses ISECT_LAT=3; sel picks the active one.
    for (genvar g = 0; g < 2; g++) begin : gen_dut
        closest_hit_ctrl #(.IDX_W(IDX_W), .ISECT_LAT(g == 0 ? 1 : 3)) dut (
            .i_clk            (clk),
            .i_rst_n          (rst_n),
            .i_start          (start && (sel == 1'(g))),
            .i_abort          (abort),
            .i_ray            (ray),
            .i_num_tri        (num_tri),
            .o_busy           (busy_v[g]),
            .o_tri_rd         (rd_v[g]),
            .o_tri_addr       (addr_v[g]),
            .i_tri_valid      (tri_valid),
            .i_tri_data       (tri_data),
            .o_isect_triangle (itri_v[g]),
            .o_isect_ray      (iray_v[g]),
            .i_isect_result   (isect_result),
            .i_isect_invalid  (isect_invalid),
            .i_isect_t        (isect_t),
            .i_isect_normal   (isect_normal),
            .o_done           (done_v[g]),
            .o_hit            (hit_v[g]),
            .o_hit_idx        (hidx_v[g]),
            .o_hit_t          (ht_v[g]),
            .o_hit_normal     (hn_v[g]),
            .o_invalid_cnt    (inv_v[g])
        );
    end

    logic                  busy, rd, done, hit;
    logic [IDX_W-1:0]      addr, hidx, inv;
    logic [0:2][0:2][31:0] itri;
    logic [0:1][0:2][31:0] iray;
    logic [31:0]           ht;
    logic [0:2][31:0]      hn;

    assign busy = busy_v[sel];
    assign rd   = rd_v[sel];
    assign addr = addr_v[sel];
    assign itri = itri_v[sel];
    assign iray = iray_v[sel];
    assign done = done_v[sel];
    assign hit  = hit_v[sel];
    assign hidx = hidx_v[sel];
    assign ht   = ht_v[sel];
    assign hn   = hn_v[sel];
    assign inv  = inv_v[sel];

    // Datapath stand-in: the triangle word itself carries the answer.
    assign isect_t       = itri[0][0];
    assign isect_result  = itri[0][1][0];
    assign isect_invalid = itri[0][1][1];
    assign isect_normal  = itri[1];

    logic [31:0] tab_t   [MAXT];
    bit          tab_hit [MAXT];
    bit          tab_inv [MAXT];
    int          tab_lat [MAXT];

    function automatic logic [0:2][0:2][31:0] mkTri(int k);
        logic [0:2][0:2][31:0] tr;
        tr       = '0;
        tr[0][0] = tab_t[k];
        tr[0][1] = {30'd0, tab_inv[k], tab_hit[k]};
        tr[0][2] = 32'(k);
        tr[1][0] = tab_t[k] ^ 32'h5A5A_0000;
        tr[1][1] = 32'(k + 1) << 16;
        tr[1][2] = 32'hFFFF_0000 - 32'(k);
        tr[2][0] = 32'hC0DE_0000 | 32'(k);
        return tr;
    endfunction

    function automatic logic [0:1][0:2][31:0] mkRay(int seed);
        logic [0:1][0:2][31:0] r;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 3; j++) begin
                r[i][j] = (32'(seed) << 16) + 32'(i * 3 + j) * 32'h0000_1111;
            end
        end
        return r;
    endfunction

    // Memory model: one response per request, tab_lat[addr] cycles after the request.
    int rd_count;
    int rd_log[$];
    initial begin
        int a;
        tri_valid = 1'b0;
        tri_data  = '1;
        rd_count  = 0;
        forever begin
            @(negedge clk);
            if (rd === 1'b1 && rst_n === 1'b1) begin
                a = int'(addr);
                if (a >= MAXT) a = MAXT - 1;
                rd_count++;
                rd_log.push_back(int'(addr));
                repeat (tab_lat[a]) @(posedge clk);
                #1;
                tri_valid = 1'b1;
                tri_data  = mkTri(a);
                @(posedge clk);
                #1;
                tri_valid = 1'b0;
                tri_data  = '1;
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic checkOutput(input string name, input logic [319:0] act, input logic [319:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // List-level model: timeline of fetch cycles and the nearest-hit reduction.
    int                    exp_n;
    int                    exp_D;
    int                    exp_fetch [MAXT+1];
    logic                  exp_hit;
    logic [IDX_W-1:0]      exp_idx;
    logic [IDX_W-1:0]      exp_inv;
    logic [31:0]           exp_t;
    logic [0:2][31:0]      exp_norm;
    logic [0:1][0:2][31:0] run_ray;
    int                    done_seen;

    task automatic buildModel(input int n, input int lat_unit);
        logic [0:2][0:2][31:0] tr;
        exp_n        = n;
        exp_fetch[0] = 1;
        for (int k = 0; k < n; k++) exp_fetch[k+1] = exp_fetch[k] + 1 + tab_lat[k] + lat_unit;
        exp_D    = exp_fetch[n];
        exp_hit  = 1'b0;
        exp_idx  = '0;
        exp_t    = '0;
        exp_norm = '0;
        exp_inv  = '0;
        for (int k = 0; k < n; k++) begin
            if (tab_inv[k]) begin
                if (exp_inv != '1) exp_inv = exp_inv + 1'b1;
            end else if (tab_hit[k] && (!exp_hit || $signed(tab_t[k]) < $signed(exp_t))) begin
                tr       = mkTri(k);
                exp_hit  = 1'b1;
                exp_idx  = IDX_W'(k);
                exp_t    = tab_t[k];
                exp_norm = tr[1];
            end
        end
    endtask

    task automatic compareCycle(input int c);
        bit rd_exp;
        int k_rd;
        rd_exp = 1'b0;
        k_rd   = 0;
        for (int k = 0; k < exp_n; k++) begin
            if (exp_fetch[k] == c) begin
                rd_exp = 1'b1;
                k_rd   = k;
            end
        end
        if (done === 1'b1 && done_seen < 0) done_seen = c;
        checkOutput($sformatf("busy@%0d", c), busy, c <= exp_D);
        checkOutput($sformatf("done@%0d", c), done, c == exp_D);
        checkOutput($sformatf("tri_rd@%0d", c), rd, rd_exp);
        if (rd_exp) checkOutput($sformatf("tri_addr@%0d", c), addr, k_rd);
        checkOutput($sformatf("isect_ray@%0d", c), iray, run_ray);
        for (int k = 0; k < exp_n; k++) begin
            if (c > exp_fetch[k] + tab_lat[k] && c < exp_fetch[k+1]) begin
                checkOutput($sformatf("isect_tri@%0d", c), itri, mkTri(k));
            end
        end
        if (c >= exp_D) begin
            checkOutput($sformatf("hit@%0d", c), hit, exp_hit);
            checkOutput($sformatf("hit_idx@%0d", c), hidx, exp_idx);
            checkOutput($sformatf("hit_t@%0d", c), ht, exp_t);
            checkOutput($sformatf("hit_normal@%0d", c), hn, exp_norm);
            checkOutput($sformatf("invalid_cnt@%0d", c), inv, exp_inv);
        end
    endtask

    task automatic setTri(input int k, input logic [31:0] t, input bit h, input bit iv, input int lat);
        tab_t[k]   = t;
        tab_hit[k] = h;
        tab_inv[k] = iv;
        tab_lat[k] = lat;
    endtask

    // Starts a traversal from a negedge in IDLE and compares every following cycle.
    task automatic applyStimulus(input bit unit, input int n, input bit misuse, input int seed);
        buildModel(n, unit ? 3 : 1);
        sel       = unit;
        run_ray   = mkRay(seed);
        ray       = run_ray;
        num_tri   = IDX_W'(n);
        start     = 1'b1;
        done_seen = -1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        ray     = ~run_ray;
        num_tri = '1;
        for (int c = 1; c <= exp_D + 2; c++) begin
            @(negedge clk);
            if (misuse && c == 2) begin
                start   = 1'b1;
                num_tri = '0;
            end
            if (misuse && c == 3) start = 1'b0;
            compareCycle(c);
        end
    endtask

    task automatic resetCheck(input string tag);
        for (int g = 0; g < 2; g++) begin
            checkOutput($sformatf("%s_busy%0d", tag, g), busy_v[g], 0);
            checkOutput($sformatf("%s_rd%0d", tag, g), rd_v[g], 0);
            checkOutput($sformatf("%s_addr%0d", tag, g), addr_v[g], 0);
            checkOutput($sformatf("%s_itri%0d", tag, g), itri_v[g], 0);
            checkOutput($sformatf("%s_iray%0d", tag, g), iray_v[g], 0);
            checkOutput($sformatf("%s_done%0d", tag, g), done_v[g], 0);
            checkOutput($sformatf("%s_hit%0d", tag, g), hit_v[g], 0);
            checkOutput($sformatf("%s_hidx%0d", tag, g), hidx_v[g], 0);
            checkOutput($sformatf("%s_ht%0d", tag, g), ht_v[g], 0);
            checkOutput($sformatf("%s_hn%0d", tag, g), hn_v[g], 0);
            checkOutput($sformatf("%s_inv%0d", tag, g), inv_v[g], 0);
        end
    endtask

    initial begin
        logic [0:2][0:2][31:0] tri_before;
        int                    rd_before;

        rst_n   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        sel     = 1'b0;
        ray     = '0;
        num_tri = '0;
        for (int k = 0; k < MAXT; k++) setTri(k, 32'h0, 1'b0, 1'b0, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetCheck("reset");
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] nearest hit");
        setTri(0, 32'h0005_0000, 1'b1, 1'b0, 1);
        setTri(1, 32'h0002_0000, 1'b1, 1'b0, 1);
        setTri(2, 32'h0004_0000, 1'b1, 1'b0, 1);
        applyStimulus(1'b0, 3, 1'b0, 1);
        checkOutput("pin_nearest_done_cycle", done_seen, 10);
        checkOutput("pin_nearest_hit", hit, 1);
        checkOutput("pin_nearest_idx", hidx, 1);
        checkOutput("pin_nearest_t", ht, 32'h0002_0000);
        checkOutput("pin_nearest_inv", inv, 0);

        $display("[TB] tie and invalid");
        setTri(0, 32'h0003_0000, 1'b1, 1'b0, 1);
        setTri(1, 32'h0001_0000, 1'b1, 1'b1, 1);
        setTri(2, 32'h0003_0000, 1'b1, 1'b0, 1);
        setTri(3, 32'h0000_8000, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 4, 1'b0, 2);
        checkOutput("pin_tie_idx", hidx, 0);
        checkOutput("pin_tie_t", ht, 32'h0003_0000);
        checkOutput("pin_tie_inv", inv, 1);

        $display("[TB] empty list");
        rd_before = rd_count;
        applyStimulus(1'b0, 0, 1'b0, 3);
        checkOutput("pin_empty_done_cycle", done_seen, 1);
        checkOutput("pin_empty_hit", hit, 0);
        checkOutput("pin_empty_no_read", rd_count, rd_before);

        $display("[TB] all misses");
        setTri(0, 32'h0001_0000, 1'b0, 1'b0, 1);
        setTri(1, 32'h0002_0000, 1'b0, 1'b0, 1);
        applyStimulus(1'b0, 2, 1'b0, 4);
        checkOutput("pin_miss_hit", hit, 0);

        $display("[TB] variable latency, ISECT_LAT=3");
        setTri(0, 32'h0007_0000, 1'b1, 1'b0, 1);
        setTri(1, 32'hFFFE_0000, 1'b1, 1'b0, 4);
        setTri(2, 32'h0001_0000, 1'b1, 1'b0, 2);
        rd_log.delete();
        applyStimulus(1'b1, 3, 1'b0, 5);
        checkOutput("pin_var_done_cycle", done_seen, 20);
        checkOutput("pin_var_req_count", rd_log.size(), 3);
        for (int i = 0; i < rd_log.size() && i < 3; i++) checkOutput($sformatf("pin_var_addr%0d", i), rd_log[i], i);
        checkOutput("pin_var_idx", hidx, 1);
        checkOutput("pin_var_t", ht, 32'hFFFE_0000);

        $display("[TB] start while busy");
        setTri(0, 32'h0005_0000, 1'b1, 1'b0, 1);
        setTri(1, 32'h0002_0000, 1'b1, 1'b0, 1);
        setTri(2, 32'h0004_0000, 1'b1, 1'b0, 1);
        applyStimulus(1'b0, 3, 1'b1, 6);
        checkOutput("pin_misuse_done_cycle", done_seen, 10);
        checkOutput("pin_misuse_idx", hidx, 1);

        $display("[TB] abort in WAIT_MEM");
        setTri(0, 32'h0001_0000, 1'b1, 1'b0, 4);
        setTri(1, 32'h0002_0000, 1'b1, 1'b0, 1);
        sel        = 1'b0;
        tri_before = itri;
        rd_before  = rd_count;
        ray        = mkRay(7);
        num_tri    = IDX_W'(2);
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        abort = 1'b1;
        for (int c = 2; c <= 10; c++) begin
            @(negedge clk);
            if (c == 3) abort = 1'b0;
            checkOutput($sformatf("abort_busy@%0d", c), busy, c <= 5);
            checkOutput($sformatf("abort_done@%0d", c), done, 0);
            if (c >= 3) checkOutput($sformatf("abort_rd@%0d", c), rd, 0);
        end
        checkOutput("abort_tri_discarded", itri, tri_before);
        checkOutput("abort_one_request", rd_count, rd_before + 1);

        $display("[TB] start after abort");
        setTri(0, 32'h0006_0000, 1'b1, 1'b0, 1);
        setTri(1, 32'h0002_8000, 1'b1, 1'b0, 1);
        applyStimulus(1'b0, 2, 1'b0, 8);
        checkOutput("pin_after_abort_idx", hidx, 1);

        $display("[TB] reset mid-EVAL");
        setTri(0, 32'h0003_0000, 1'b1, 1'b0, 1);
        setTri(1, 32'h0002_0000, 1'b1, 1'b0, 1);
        setTri(2, 32'h0001_0000, 1'b1, 1'b0, 1);
        sel     = 1'b0;
        ray     = mkRay(9);
        num_tri = IDX_W'(3);
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 6; c++) @(negedge clk);
        checkOutput("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        resetCheck("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        applyStimulus(1'b0, 3, 1'b0, 10);
        checkOutput("pin_post_reset_idx", hidx, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/closest_hit_ctrl.md
# closest_hit_ctrl

Sequencing controller for the combinational ray/triangle intersection datapath. On a start command it walks a triangle list in external memory, one triangle at a time. Each triangle is presented with the latched ray to the intersection unit, and the controller keeps the nearest valid hit (smallest t). It sits between the ray dispatcher and the triangle memory, and owns the intersection unit exclusively.

## Interface

Parameters:
- IDX_W, 16, width of triangle index / count.
- ISECT_LAT, 1, cycles the datapath inputs are held before its outputs are sampled (≥1).

Ports:
- i_clk  in  1  clock; one clock domain.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  begin a traversal; honoured only in IDLE.
- i_abort  in  1  cancel a traversal; no o_done is produced.
- i_ray  in  [0:1][0:2][31:0]  origin, direction, Q16.16 signed; latched at start.
- i_num_tri  in  IDX_W  triangle count; latched at start.
- o_busy  out  1  high in every state except IDLE.
- o_tri_rd  out  1  one-cycle triangle read request.
- o_tri_addr  out  IDX_W  triangle index being fetched.
- i_tri_valid  in  1  read data valid; exactly one response per request, latency ≥1.
- i_tri_data  in  [0:2][0:2][31:0]  three vertices.
- o_isect_triangle  out  [0:2][0:2][31:0]  registered datapath input.
- o_isect_ray  out  [0:1][0:2][31:0]  registered datapath input.
- i_isect_result, i_isect_invalid  in  1 each  datapath hit flag and overflow flag.
- i_isect_t  in  32  signed hit distance.
- i_isect_normal  in  [0:2][31:0]  normal.
- o_done  out  1  one-cycle completion pulse.
- o_hit  out  1  a valid hit was found.
- o_hit_idx  out  IDX_W  index of the nearest hit.
- o_hit_t  out  32  distance of the nearest hit.
- o_hit_normal  out  [0:2][31:0]  normal of the nearest hit.
- o_invalid_cnt  out  IDX_W  triangles whose datapath flagged invalid, saturating.

## Operation

States: IDLE, FETCH, WAIT_MEM, EVAL, DONE, DRAIN.

- **IDLE.** On i_start:
  - latch i_ray into o_isect_ray and latch i_num_tri;
  - set idx=0 and clear o_hit, o_hit_idx, o_hit_t, o_hit_normal, o_invalid_cnt;
  - go to FETCH, or to DONE if i_num_tri==0.
- **FETCH.** Drive o_tri_rd=1 and o_tri_addr=idx, then go to WAIT_MEM.
- **WAIT_MEM.** On i_tri_valid, capture i_tri_data into o_isect_triangle, load the EVAL counter with ISECT_LAT, and go to EVAL.
- **EVAL.** Count down. On the last EVAL cycle, sample the datapath:
  - if i_isect_invalid: increment o_invalid_cnt, saturating at all-ones, and do not treat it as a hit;
  - else if i_isect_result and (!o_hit or i_isect_t < o_hit_t, signed): set o_hit=1 and record idx, t and normal;
  - equal t keeps the earlier index (strict less-than);
  - then go to DONE if idx==num-1, else idx+1 and FETCH.
- **DONE.** o_done=1 for one cycle, then IDLE. Result outputs hold until the next accepted start.
- **Abort.** i_abort has priority over all transitions:
  - from FETCH, EVAL or DONE: go to IDLE;
  - from WAIT_MEM: go to DRAIN, which waits for the outstanding i_tri_valid (data discarded), then IDLE.
- **Misuse and stray inputs.**
  - i_start outside IDLE is ignored.
  - i_tri_valid outside WAIT_MEM/DRAIN is ignored.
  - The o_isect_* registers change only at start or capture.

## Timing

- **Reset values.** State IDLE; all outputs 0, including o_isect_triangle, o_isect_ray and o_tri_addr.
- **Start.** Start is sampled at edge S, and FETCH is the cycle after S.
- **Per-triangle cost.** 1 (FETCH) + L (WAIT_MEM cycles, including the valid cycle) + ISECT_LAT.
- **Total latency.** With L=1 and ISECT_LAT=1, N triangles take 3N cycles. o_done is asserted in cycle 3N+1 after S; for N=0 it is asserted in cycle 1.
- **o_tri_rd.** Asserted only in FETCH, so there is at most one outstanding read.
- **Abort latency.**
  - o_busy drops the cycle after the abort, except from WAIT_MEM, where it stays high until the drained valid has been received.
  - A new start is accepted in the first IDLE cycle.

## Test plan

- **Nearest hit.** Q16.16, N=3, L=1, ISECT_LAT=1; datapath model returns hits with t = 0x0005_0000, 0x0002_0000, 0x0004_0000 → o_done in cycle 10 after start, o_hit=1, o_hit_idx=1, o_hit_t=0x0002_0000, o_invalid_cnt=0.
- **Tie and invalid.** N=4; t = 0x0003_0000 at idx 0 and idx 2; idx 1 hit with invalid=1 and t=0x0001_0000; idx 3 miss → o_hit_idx=0, o_hit_t=0x0003_0000, o_invalid_cnt=1.
- **Empty list.** N=0 → no o_tri_rd, o_done in cycle 1, o_hit=0. All misses with N=2 → o_done, o_hit=0.
- **Variable latency.** Memory latencies 1, 4, 2 with ISECT_LAT=3 → o_tri_addr sequence 0,1,2, one request per fetch, o_done in cycle 3·(1+3)+7+1=20.
- **Abort in WAIT_MEM.** Assert i_abort during WAIT_MEM; valid arrives 3 cycles later → state DRAIN, response discarded, o_busy low the cycle after the valid, no o_done. The next start completes correctly.
- **Reset and misuse.** Assert i_rst_n low mid-EVAL → all outputs 0 immediately (asynchronous). i_start pulsed while busy → ignored; results unchanged.
